// File: rtl/sbox_share_ctrl.sv
// Four shared AES S-box lanes arbitrated between a 128-bit SubBytes requester
// (one 32-bit word per grant) and a 32-bit key-expansion SubWord requester.

module sbox_lane (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 in GF(2^8); zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] v);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    assign dout = affine(gf_inv(din));
endmodule

module sbox_share_ctrl #(
    parameter bit KW_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sb_start,
    input  logic [127:0] sb_in,
    output logic         sb_busy,
    output logic         sb_done,
    output logic [127:0] sb_out,
    input  logic         kw_start,
    input  logic [31:0]  kw_in,
    output logic         kw_busy,
    output logic         kw_done,
    output logic [31:0]  kw_out
);
    typedef enum logic [1:0] {IDLE, SB_RUN, KW_RUN} state_t;

    state_t       state, state_nxt;
    logic         grant_sb, grant_kw;
    logic [1:0]   idx;
    logic [127:0] sb_in_q;
    logic [31:0]  kw_in_q;
    logic [31:0]  lane_in, lane_out;

    // A captured request sets busy, so busy alone marks eligibility from the
    // following edge. The state records who held the lanes at the last edge.
    always_comb begin
        state_nxt = IDLE;
        grant_sb  = 1'b0;
        grant_kw  = 1'b0;
        if (sb_busy && kw_busy) begin
            if (state == KW_RUN || !KW_FIRST) grant_sb = 1'b1;
            else                              grant_kw = 1'b1;
        end else if (sb_busy) begin
            grant_sb = 1'b1;
        end else if (kw_busy) begin
            grant_kw = 1'b1;
        end
        if (grant_sb)      state_nxt = SB_RUN;
        else if (grant_kw) state_nxt = KW_RUN;
    end

    always_comb begin
        lane_in = kw_in_q;
        if (!grant_kw) begin
            case (idx)
                2'd0:    lane_in = sb_in_q[127:96];
                2'd1:    lane_in = sb_in_q[95:64];
                2'd2:    lane_in = sb_in_q[63:32];
                default: lane_in = sb_in_q[31:0];
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        sbox_lane u_lane (
            .din  (lane_in[8*g +: 8]),
            .dout (lane_out[8*g +: 8])
        );
    end

    // Captured operands need no reset: they are only read while busy is set.
    always_ff @(posedge clk) begin
        if (sb_start && !sb_busy) sb_in_q <= sb_in;
        if (kw_start && !kw_busy) kw_in_q <= kw_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 2'd0;
            sb_busy <= 1'b0;
            sb_done <= 1'b0;
            sb_out  <= '0;
            kw_busy <= 1'b0;
            kw_done <= 1'b0;
            kw_out  <= '0;
        end else begin
            state   <= state_nxt;
            sb_done <= 1'b0;
            kw_done <= 1'b0;
            if (sb_start && !sb_busy) sb_busy <= 1'b1;
            if (kw_start && !kw_busy) kw_busy <= 1'b1;
            if (grant_sb) begin
                case (idx)
                    2'd0:    sb_out[127:96] <= lane_out;
                    2'd1:    sb_out[95:64]  <= lane_out;
                    2'd2:    sb_out[63:32]  <= lane_out;
                    default: sb_out[31:0]   <= lane_out;
                endcase
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    sb_busy <= 1'b0;
                    sb_done <= 1'b1;
                end
            end
            if (grant_kw) begin
                kw_out  <= lane_out;
                kw_busy <= 1'b0;
                kw_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Scoreboard bench for sbox_share_ctrl: one instance per priority setting,
// expected data and completion edge queued at start, checked on done.

module tb_sbox_share_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] sb_in;
    logic [31:0]  kw_in;
    logic         sb_start1, kw_start1, sb_busy1, sb_done1, kw_busy1, kw_done1;
    logic         sb_start0, kw_start0, sb_busy0, sb_done0, kw_busy0, kw_done0;
    logic [127:0] sb_out1, sb_out0;
    logic [31:0]  kw_out1, kw_out0;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t sbq1[$], kwq1[$], sbq0[$], kwq0[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ce;

    localparam logic [127:0] SB_A  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] SB_AX = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;

    logic [7:0] sbox_tbl [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    sbox_share_ctrl #(.KW_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .sb_start(sb_start1), .sb_in(sb_in), .sb_busy(sb_busy1), .sb_done(sb_done1), .sb_out(sb_out1),
        .kw_start(kw_start1), .kw_in(kw_in), .kw_busy(kw_busy1), .kw_done(kw_done1), .kw_out(kw_out1)
    );

    sbox_share_ctrl #(.KW_FIRST(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .sb_start(sb_start0), .sb_in(sb_in), .sb_busy(sb_busy0), .sb_done(sb_done0), .sb_out(sb_out0),
        .kw_start(kw_start0), .kw_in(kw_in), .kw_busy(kw_busy0), .kw_done(kw_done0), .kw_out(kw_out0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sb_done1) begin
                check_val("sb1_pending", 128'(sbq1.size() > 0), 128'd1);
                if (sbq1.size() > 0) begin
                    e = sbq1.pop_front();
                    check_val("sb1_out", sb_out1, e.data);
                    check_val("sb1_done_edge", 128'(cyc), 128'(e.due));
                    check_val("sb1_busy_clr", 128'(sb_busy1), 128'd0);
                end
            end
            if (kw_done1) begin
                check_val("kw1_pending", 128'(kwq1.size() > 0), 128'd1);
                if (kwq1.size() > 0) begin
                    e = kwq1.pop_front();
                    check_val("kw1_out", 128'(kw_out1), e.data);
                    check_val("kw1_done_edge", 128'(cyc), 128'(e.due));
                    check_val("kw1_busy_clr", 128'(kw_busy1), 128'd0);
                end
            end
            if (sb_done0) begin
                check_val("sb0_pending", 128'(sbq0.size() > 0), 128'd1);
                if (sbq0.size() > 0) begin
                    e = sbq0.pop_front();
                    check_val("sb0_out", sb_out0, e.data);
                    check_val("sb0_done_edge", 128'(cyc), 128'(e.due));
                end
            end
            if (kw_done0) begin
                check_val("kw0_pending", 128'(kwq0.size() > 0), 128'd1);
                if (kwq0.size() > 0) begin
                    e = kwq0.pop_front();
                    check_val("kw0_out", 128'(kw_out0), e.data);
                    check_val("kw0_done_edge", 128'(cyc), 128'(e.due));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_starts(input logic s1, input logic k1, input logic s0, input logic k0);
        sb_start1 = s1;
        kw_start1 = k1;
        sb_start0 = s0;
        kw_start0 = k0;
    endtask

    function automatic int pending();
        return sbq1.size() + kwq1.size() + sbq0.size() + kwq0.size();
    endfunction

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (pending() == 0) break;
            step(1);
        end
        check_val(tag, 128'(pending()), 128'd0);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_sb_out1"}, sb_out1, 128'd0);
        check_val({tag, "_kw_out1"}, 128'(kw_out1), 128'd0);
        check_val({tag, "_flags1"}, 128'({sb_busy1, sb_done1, kw_busy1, kw_done1}), 128'd0);
        check_val({tag, "_sb_out0"}, sb_out0, 128'd0);
        check_val({tag, "_kw_out0"}, 128'(kw_out0), 128'd0);
        check_val({tag, "_flags0"}, 128'({sb_busy0, sb_done0, kw_busy0, kw_done0}), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] rs;
        logic [31:0]  rk;
        rst_n = 1'b0;
        sb_in = '0;
        kw_in = '0;
        set_starts(0, 0, 0, 0);
        step(3);
        check_cleared("reset");

        // Release reset with starts already present for the first edge.
        rst_n = 1'b1;
        sb_in = SB_A;
        set_starts(1, 0, 1, 0);
        ce = cyc + 1;
        sbq1.push_back('{SB_AX, ce + 4});
        sbq0.push_back('{SB_AX, ce + 4});
        step(1);
        set_starts(0, 0, 0, 0);
        drain("drain_sb_vec");

        kw_in = 32'h01020304;
        set_starts(0, 1, 0, 1);
        ce = cyc + 1;
        kwq1.push_back('{128'h7c777bf2, ce + 1});
        kwq0.push_back('{128'h7c777bf2, ce + 1});
        step(1);
        set_starts(0, 0, 0, 0);
        drain("drain_kw_vec");

        for (int t = 0; t < 3; t++) begin
            rs = {$urandom, $urandom, $urandom, $urandom};
            rk = $urandom;
            sb_in = rs;
            set_starts(1, 0, 1, 0);
            ce = cyc + 1;
            sbq1.push_back('{sub_state(rs), ce + 4});
            sbq0.push_back('{sub_state(rs), ce + 4});
            step(1);
            set_starts(0, 0, 0, 0);
            drain("drain_sb_rand");
            kw_in = rk;
            set_starts(0, 1, 0, 1);
            ce = cyc + 1;
            kwq1.push_back('{128'(sub_word(rk)), ce + 1});
            kwq0.push_back('{128'(sub_word(rk)), ce + 1});
            step(1);
            set_starts(0, 0, 0, 0);
            drain("drain_kw_rand");
        end

        // SB first, KW one edge later, key-word priority.
        sb_in = SB_A;
        set_starts(1, 0, 0, 0);
        ce = cyc + 1;
        sbq1.push_back('{SB_AX, ce + 5});
        step(1);
        kw_in = 32'hdeadbeef;
        set_starts(0, 1, 0, 0);
        kwq1.push_back('{128'(sub_word(32'hdeadbeef)), ce + 2});
        step(1);
        set_starts(0, 0, 0, 0);
        drain("drain_contend_kw1");

        // Simultaneous starts on both priority settings.
        rs = {$urandom, $urandom, $urandom, $urandom};
        sb_in = rs;
        kw_in = 32'h0055aaff;
        set_starts(1, 1, 1, 1);
        ce = cyc + 1;
        sbq0.push_back('{sub_state(rs), ce + 4});
        kwq0.push_back('{128'(sub_word(32'h0055aaff)), ce + 5});
        kwq1.push_back('{128'(sub_word(32'h0055aaff)), ce + 1});
        sbq1.push_back('{sub_state(rs), ce + 5});
        step(1);
        set_starts(0, 0, 0, 0);
        drain("drain_simul");

        // KW requested at every accepting edge while SB runs: grants alternate.
        sb_in = SB_A;
        kw_in = 32'h13579bdf;
        set_starts(1, 1, 0, 0);
        ce = cyc + 1;
        sbq1.push_back('{SB_AX, ce + 8});
        for (int j = 0; j < 5; j++)
            kwq1.push_back('{128'(sub_word(32'h13579bdf)), ce + 1 + 2 * j});
        step(1);
        set_starts(0, 1, 0, 0);
        step(8);
        set_starts(0, 0, 0, 0);
        drain("drain_starve");

        // Reset after word 1 of an SB request: everything clears, no done.
        sb_in = SB_A;
        set_starts(1, 0, 1, 0);
        step(1);
        set_starts(0, 0, 0, 0);
        step(2);
        rst_n = 1'b0;
        #1;
        check_cleared("midreset");
        step(2);
        rst_n = 1'b1;
        set_starts(1, 0, 1, 0);
        ce = cyc + 1;
        sbq1.push_back('{SB_AX, ce + 4});
        sbq0.push_back('{SB_AX, ce + 4});
        step(1);
        set_starts(0, 0, 0, 0);
        drain("drain_after_reset");

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
